alu_ctrl: RTL and testbench
===========================

# alu_ctrl

Multi-cycle controller that issues operations to the 8-bit ALU and stores the results. It accepts 8-bit instruction words over a valid/ready handshake and reads operands from an internal 4×8 register file. It drives A/B/ALUOP to the ALU, samples Y, writes the result back and pulses DONE. It is the initiator side of the ALU interface and sits between the instruction source and the ALU.

## Interface
- NREG, 4, number of 8-bit registers. The 2-bit address fields fix this value at 4.
- WIDTH, 8, datapath width. It must equal the ALU width.

- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- INSTR  in  8  instruction: [7:6] op, [5:4] rd, [3:2] ra, [1:0] rb.
- IVALID  in  1  INSTR is valid.
- IREADY  out  1  the controller can accept an instruction.
- A  out  8  ALU operand A, registered.
- B  out  8  ALU operand B, registered.
- ALUOP  out  1  ALU operation select, registered. 1 selects add; 0 makes the ALU output 0.
- Y  in  8  ALU result, combinational from A/B/ALUOP.
- DONE  out  1  one-cycle pulse when an instruction retires.
- RESULT  out  8  value written back by the retiring instruction. Valid while DONE=1.
- RADDR  in  2  debug register read address.
- RDATA  out  8  register[RADDR], combinational.

## Operation
- Opcodes:
  - 00 NOP: no write.
  - 01 ADD: rd ← ra + rb, mod 256, carry discarded.
  - 10 LDI: rd ← {4'b0, INSTR[3:0]}.
  - 11 CLR: rd ← Y with ALUOP=0, which is 0.
- FSM states: IDLE → READ → EXEC → WB → IDLE.
  - IDLE: IREADY=1. When IVALID=1, latch INSTR and go to READ.
  - READ: load A←reg[ra] and B←reg[rb]. Load ALUOP←1 only if op=ADD, else ALUOP←0.
  - EXEC: operands are stable at the ALU. At the end of the cycle, latch the write-back value: Y for ADD or CLR, the immediate for LDI, 0 for NOP.
  - WB: write reg[rd] unless NOP. Set DONE=1 and RESULT=latched value. Clear ALUOP to 0. Return to IDLE.
- A and B hold their last values after an instruction; only ALUOP is cleared.
- IREADY is 0 in READ, EXEC and WB. IVALID is ignored there, and the source must hold INSTR until accepted.
- Register r0 is an ordinary register; it is not hardwired to zero.
- rd may equal ra and/or rb. Operands are read in READ, before the write in WB, so the old values are used.
- RDATA reflects a write-back from the cycle after the WB edge.
- Reset:
  - All registers go to 0 and the state goes to IDLE.
  - A=0, B=0, ALUOP=0, DONE=0, RESULT=0, IREADY=1 on the first cycle after reset.
- Reset mid-instruction aborts it. There is no DONE and no register write, and everything returns to reset values.

## Timing
- The handshake completes at edge k, when IVALID=1 and IREADY=1.
- READ runs in cycle k+1. A, B and ALUOP are valid from edge k+2.
- EXEC runs in cycle k+2, and Y is sampled at edge k+3.
- WB runs in cycle k+3: DONE=1 and RESULT valid. The register is written at edge k+4.
- IREADY returns to 1 in cycle k+4.
- Latency from accept to DONE is 3 cycles. Throughput is one instruction per 4 cycles.
- A back-to-back instruction presented with IVALID held high is accepted at edge k+4. It reads the just-written register correctly.
- DONE is exactly one cycle wide and is never asserted in IDLE.

## Structure
- A shared package, alu_pkg, holds:
  - opcode constants OP_NOP, OP_ADD, OP_LDI, OP_CLR;
  - state encodings S_IDLE, S_READ, S_EXEC, S_WB;
  - INSTR field bit positions;
  - WIDTH.
- Sub-module alu_regfile holds the 4×8 storage:
  - two combinational read ports for operands, plus a third for debug;
  - one synchronous write port;
  - synchronous reset that clears all entries.
- The bench top instantiates alu_ctrl with the existing ALU connected on A/B/ALUOP/Y.

## Test plan
- Reset then idle: assert RST for 2 cycles → A=B=0, ALUOP=0, DONE=0, IREADY=1, RDATA=0 for every RADDR.
- LDI then ADD:
  - LDI r1,5 then LDI r2,9 → RDATA(r1)=5, RDATA(r2)=9.
  - ADD r3←r1+r2 → DONE 3 cycles after accept, RESULT=14, ALUOP=1 during EXEC only.
- Overflow: r1=0x0F and r2=0x0F are loaded, then ADD r0←r0+r0 with r0=0x80 (built by adds) → RESULT=0x00, with wrap and no carry.
- Aliasing: r1=7, then ADD r1←r1+r1 → RESULT=14 and r1=14. Back-to-back with IVALID held high: a second ADD r1←r1+r1 gives 28, accepted exactly 4 cycles after the first.
- CLR/NOP:
  - CLR r2 → RESULT=0, r2=0, ALUOP=0 throughout.
  - NOP → DONE pulses, RESULT=0, no register changes.
- Reset mid-op: assert RST during EXEC of ADD r3 → no DONE pulse, r3=0, IREADY=1 the cycle after RST drops.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants, encodings and instruction-field helpers for the ALU controller.
package alu_pkg;

   localparam int WIDTH = 8;
   localparam int NREG  = 4;
   localparam int AW    = 2;
   localparam int IW    = 8;

   localparam int OP_LSB = 6;
   localparam int RD_LSB = 4;
   localparam int RA_LSB = 2;
   localparam int RB_LSB = 0;
   localparam int IMM_W  = 4;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_ADD = 2'b01,
      OP_LDI = 2'b10,
      OP_CLR = 2'b11
   } opcode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_READ = 2'b01,
      S_EXEC = 2'b10,
      S_WB   = 2'b11
   } state_t;

   function automatic opcode_t instr_op(input logic [IW-1:0] i);
      return opcode_t'(i[OP_LSB +: 2]);
   endfunction

   function automatic logic [AW-1:0] instr_rd(input logic [IW-1:0] i);
      return i[RD_LSB +: AW];
   endfunction

   function automatic logic [AW-1:0] instr_ra(input logic [IW-1:0] i);
      return i[RA_LSB +: AW];
   endfunction

   function automatic logic [AW-1:0] instr_rb(input logic [IW-1:0] i);
      return i[RB_LSB +: AW];
   endfunction

   // The immediate overlays the ra/rb fields.
   function automatic logic [IMM_W-1:0] instr_imm(input logic [IW-1:0] i);
      return i[IMM_W-1:0];
   endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction handshake, ALU operand/result bus and debug read port of alu_ctrl.
interface alu_ctrl_if
   import alu_pkg::*;
();
   logic [IW-1:0]    instr;
   logic             ivalid;
   logic             iready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             aluop;
   logic [WIDTH-1:0] y;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [AW-1:0]    raddr;
   logic [WIDTH-1:0] rdata;

   // master: instruction source plus the ALU; slave: the controller
   modport master (
      output instr, ivalid, y, raddr,
      input  iready, a, b, aluop, done, result, rdata
   );

   modport slave (
      input  instr, ivalid, y, raddr,
      output iready, a, b, aluop, done, result, rdata
   );
endinterface

// File: rtl/alu_regfile.sv
// 4x8 register file: two operand read ports, one debug read port, one synchronous write port.
module alu_regfile
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    ra_addr,
   input  logic [AW-1:0]    rb_addr,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] ra_data,
   output logic [WIDTH-1:0] rb_data,
   output logic [WIDTH-1:0] dbg_data,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata
);

   logic [WIDTH-1:0] regs [NREG];

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         logic [WIDTH-1:0] q_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               q_reg <= '0;
            end else if (we && (waddr == AW'(gi))) begin
               q_reg <= wdata;
            end
         end

         assign regs[gi] = q_reg;
      end
   endgenerate

   assign ra_data  = regs[ra_addr];
   assign rb_data  = regs[rb_addr];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle controller: accepts an instruction, drives the external ALU, writes the result back.
module alu_ctrl
   import alu_pkg::*;
(
   input logic       clk,
   input logic       rst,
   alu_ctrl_if.slave bus
);

   state_t           state_reg, state_next;
   logic [IW-1:0]    instr_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             aluop_reg;
   logic [WIDTH-1:0] wb_reg;

   logic             load_instr;
   logic             load_ops;
   logic             latch_wb;
   logic             reg_we;
   logic [WIDTH-1:0] wb_value;
   logic [WIDTH-1:0] ra_data;
   logic [WIDTH-1:0] rb_data;
   opcode_t          op;

   assign op = instr_op(instr_reg);

   alu_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .ra_addr  (instr_ra(instr_reg)),
      .rb_addr  (instr_rb(instr_reg)),
      .dbg_addr (bus.raddr),
      .ra_data  (ra_data),
      .rb_data  (rb_data),
      .dbg_data (bus.rdata),
      .we       (reg_we),
      .waddr    (instr_rd(instr_reg)),
      .wdata    (wb_reg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      load_instr = 1'b0;
      load_ops   = 1'b0;
      latch_wb   = 1'b0;
      reg_we     = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (bus.ivalid) begin
               load_instr = 1'b1;
               state_next = S_READ;
            end
         end
         S_READ: begin
            load_ops   = 1'b1;
            state_next = S_EXEC;
         end
         S_EXEC: begin
            latch_wb   = 1'b1;
            state_next = S_WB;
         end
         S_WB: begin
            reg_we     = (op != OP_NOP);
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      wb_value = '0;
      case (op)
         OP_ADD, OP_CLR: wb_value = bus.y;
         OP_LDI:         wb_value = WIDTH'(instr_imm(instr_reg));
         default:        wb_value = '0;
      endcase
   end

   // ALUOP is dropped on the same edge that samples Y, so it is high only during EXEC.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_reg <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         aluop_reg <= 1'b0;
         wb_reg    <= '0;
      end else begin
         if (load_instr) begin
            instr_reg <= bus.instr;
         end
         if (load_ops) begin
            a_reg     <= ra_data;
            b_reg     <= rb_data;
            aluop_reg <= (op == OP_ADD);
         end
         if (latch_wb) begin
            wb_reg    <= wb_value;
            aluop_reg <= 1'b0;
         end
      end
   end

   assign bus.iready = (state_reg == S_IDLE);
   assign bus.done   = (state_reg == S_WB);
   assign bus.result = wb_reg;
   assign bus.a      = a_reg;
   assign bus.b      = b_reg;
   assign bus.aluop  = aluop_reg;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl with a behavioural adder ALU and a register-file model.
module tb_alu_ctrl;
   import alu_pkg::*;

   localparam int P = 10;

   logic clk = 1'b0;
   logic rst;
   always #(P/2) clk = ~clk;

   alu_ctrl_if bus();

   // The ALU: add when ALUOP=1, zero otherwise.
   assign bus.y = bus.aluop ? (bus.a + bus.b) : '0;

   alu_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] mdl [4];
   logic [7:0] exp_q [$];

   function automatic logic [7:0] enc(input opcode_t op, input int rd, input int ra, input int rb);
      logic [7:0] w;
      w = {op, rd[1:0], ra[1:0], rb[1:0]};
      return w;
   endfunction

   function automatic logic [7:0] enc_ldi(input int rd, input int imm);
      logic [7:0] w;
      w = {OP_LDI, rd[1:0], imm[3:0]};
      return w;
   endfunction

   // Architectural model: returns the write-back value and updates the model registers.
   function automatic logic [7:0] model(input logic [7:0] ins);
      logic [7:0] r;
      r = 8'h00;
      case (ins[7:6])
         2'b01: r = mdl[ins[3:2]] + mdl[ins[1:0]];
         2'b10: r = {4'b0000, ins[3:0]};
         default: r = 8'h00;
      endcase
      if (ins[7:6] != 2'b00) mdl[ins[5:4]] = r;
      return r;
   endfunction

   task automatic send(input logic [7:0] ins, output logic ok);
      @(negedge clk);
      bus.instr  = ins;
      bus.ivalid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.iready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.ivalid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 12);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.ivalid = 1'b0;
      bus.instr  = 8'h00;
      bus.raddr  = 2'd0;
      for (int r = 0; r < 4; r++) mdl[r] = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.a !== 8'h00)    begin n_fail++; $display("FAIL reset_a: got %0h expected 0", bus.a); end
      n_checks++; if (bus.b !== 8'h00)    begin n_fail++; $display("FAIL reset_b: got %0h expected 0", bus.b); end
      n_checks++; if (bus.aluop !== 1'b0) begin n_fail++; $display("FAIL reset_aluop: got %0b expected 0", bus.aluop); end
      n_checks++; if (bus.done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
      n_checks++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %0h expected 0", bus.result); end
      n_checks++; if (bus.iready !== 1'b1) begin n_fail++; $display("FAIL reset_iready: got %0b expected 1", bus.iready); end
      for (int r = 0; r < 4; r++) begin
         bus.raddr = 2'(r);
         #1;
         n_checks++;
         if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata r%0d: got %0h expected 0", r, bus.rdata); end
      end
      $display("reset: done");
   endtask

   task automatic test_ldi_add;
      logic [7:0] tbl [2];
      logic [7:0] ins, e;
      logic ok;
      int n;
      tbl[0] = enc_ldi(1, 5);
      tbl[1] = enc_ldi(2, 9);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(model(tbl[i]));
         send(tbl[i], ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL ldi_accept: got 0 expected 1"); end
         wait_done(n);
         e = exp_q.pop_front();
         n_checks++; if (n !== 3) begin n_fail++; $display("FAIL ldi_latency: got %0d expected 3", n); end
         n_checks++; if (bus.result !== e) begin n_fail++; $display("FAIL ldi_result: got %0h expected %0h", bus.result, e); end
         $display("ldi instr=%02h result=%02h latency=%0d", tbl[i], bus.result, n);
      end
      @(negedge clk);
      for (int r = 1; r < 3; r++) begin
         bus.raddr = 2'(r);
         #1;
         n_checks++; if (bus.rdata !== mdl[r]) begin n_fail++; $display("FAIL ldi_rdata r%0d: got %0h expected %0h", r, bus.rdata, mdl[r]); end
      end

      ins = enc(OP_ADD, 3, 1, 2);
      exp_q.push_back(model(ins));
      send(ins, ok);
      @(negedge clk);
      n_checks++; if (bus.aluop !== 1'b0) begin n_fail++; $display("FAIL add_aluop_read: got %0b expected 0", bus.aluop); end
      @(negedge clk);
      n_checks++; if (bus.aluop !== 1'b1) begin n_fail++; $display("FAIL add_aluop_exec: got %0b expected 1", bus.aluop); end
      n_checks++; if (bus.a !== 8'd5 || bus.b !== 8'd9) begin n_fail++; $display("FAIL add_operands: got %0h/%0h expected 5/9", bus.a, bus.b); end
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %0b expected 1", bus.done); end
      n_checks++; if (bus.result !== e) begin n_fail++; $display("FAIL add_result: got %0h expected %0h", bus.result, e); end
      n_checks++; if (bus.aluop !== 1'b0) begin n_fail++; $display("FAIL add_aluop_wb: got %0b expected 0", bus.aluop); end
      $display("add instr=%02h result=%02h", ins, bus.result);
      @(negedge clk);
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_width: got %0b expected 0", bus.done); end
      bus.raddr = 2'd3;
      #1;
      n_checks++; if (bus.rdata !== mdl[3]) begin n_fail++; $display("FAIL add_rdata r3: got %0h expected %0h", bus.rdata, mdl[3]); end
   endtask

   task automatic test_overflow;
      logic [7:0] tbl [9];
      logic [7:0] e;
      logic ok;
      int n;
      tbl[0] = enc_ldi(1, 15);
      tbl[1] = enc_ldi(2, 15);
      tbl[2] = enc(OP_ADD, 3, 1, 2);
      tbl[3] = enc_ldi(0, 8);
      for (int i = 4; i < 9; i++) tbl[i] = enc(OP_ADD, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(model(tbl[i]));
         send(tbl[i], ok);
         wait_done(n);
         e = exp_q.pop_front();
         n_checks++; if (bus.done !== 1'b1 || bus.result !== e) begin n_fail++; $display("FAIL ovf_result step %0d: got %0h expected %0h", i, bus.result, e); end
         $display("ovf instr=%02h result=%02h", tbl[i], bus.result);
      end
      n_checks++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL ovf_wrap: got %0h expected 0", bus.result); end
      @(negedge clk);
      bus.raddr = 2'd0;
      #1;
      n_checks++; if (bus.rdata !== mdl[0]) begin n_fail++; $display("FAIL ovf_rdata r0: got %0h expected %0h", bus.rdata, mdl[0]); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] ins, e;
      logic ok;
      int n;
      time t1, t2;
      exp_q.push_back(model(enc_ldi(1, 7)));
      send(enc_ldi(1, 7), ok);
      wait_done(n);
      e = exp_q.pop_front();
      n_checks++; if (bus.result !== e) begin n_fail++; $display("FAIL b2b_ldi: got %0h expected %0h", bus.result, e); end

      ins = enc(OP_ADD, 1, 1, 1);
      exp_q.push_back(model(ins));
      exp_q.push_back(model(ins));
      @(negedge clk);
      bus.instr  = ins;
      bus.ivalid = 1'b1;
      n = 0;
      while (!bus.iready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      t1 = $time;
      wait_done(n);
      e = exp_q.pop_front();
      n_checks++; if (n !== 3 || bus.result !== e) begin n_fail++; $display("FAIL b2b_first: got %0h lat %0d expected %0h lat 3", bus.result, n, e); end
      $display("b2b first instr=%02h result=%02h", ins, bus.result);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.iready && n < 20);
      @(posedge clk);
      t2 = $time;
      #1 bus.ivalid = 1'b0;
      n_checks++; if ((t2 - t1) !== 4 * P) begin n_fail++; $display("FAIL b2b_spacing: got %0t expected %0t", t2 - t1, 4 * P); end
      wait_done(n);
      e = exp_q.pop_front();
      n_checks++; if (n !== 3 || bus.result !== e) begin n_fail++; $display("FAIL b2b_second: got %0h lat %0d expected %0h lat 3", bus.result, n, e); end
      $display("b2b second instr=%02h result=%02h", ins, bus.result);
      @(negedge clk);
      bus.raddr = 2'd1;
      #1;
      n_checks++; if (bus.rdata !== mdl[1]) begin n_fail++; $display("FAIL b2b_rdata r1: got %0h expected %0h", bus.rdata, mdl[1]); end
   endtask

   task automatic test_clr_nop;
      logic [7:0] ins, e;
      logic ok;
      int n;
      logic seen_aluop;
      ins = enc(OP_CLR, 2, 1, 1);
      exp_q.push_back(model(ins));
      send(ins, ok);
      seen_aluop = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (bus.aluop) seen_aluop = 1'b1;
      end while (!bus.done && n < 12);
      e = exp_q.pop_front();
      n_checks++; if (seen_aluop !== 1'b0) begin n_fail++; $display("FAIL clr_aluop: got 1 expected 0"); end
      n_checks++; if (n !== 3 || bus.result !== e) begin n_fail++; $display("FAIL clr_result: got %0h lat %0d expected %0h lat 3", bus.result, n, e); end
      $display("clr instr=%02h result=%02h", ins, bus.result);
      @(negedge clk);
      bus.raddr = 2'd2;
      #1;
      n_checks++; if (bus.rdata !== mdl[2]) begin n_fail++; $display("FAIL clr_rdata r2: got %0h expected %0h", bus.rdata, mdl[2]); end

      ins = enc(OP_NOP, 3, 1, 1);
      exp_q.push_back(model(ins));
      send(ins, ok);
      wait_done(n);
      e = exp_q.pop_front();
      n_checks++; if (n !== 3 || bus.result !== e) begin n_fail++; $display("FAIL nop_result: got %0h lat %0d expected %0h lat 3", bus.result, n, e); end
      $display("nop instr=%02h result=%02h", ins, bus.result);
      @(negedge clk);
      for (int r = 0; r < 4; r++) begin
         bus.raddr = 2'(r);
         #1;
         n_checks++; if (bus.rdata !== mdl[r]) begin n_fail++; $display("FAIL nop_rdata r%0d: got %0h expected %0h", r, bus.rdata, mdl[r]); end
      end
   endtask

   task automatic test_reset_mid;
      logic ok;
      logic seen_done;
      send(enc(OP_ADD, 3, 1, 1), ok);
      seen_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
      rst = 1'b0;
      for (int r = 0; r < 4; r++) mdl[r] = 8'h00;
      @(negedge clk);
      n_checks++; if (bus.iready !== 1'b1) begin n_fail++; $display("FAIL rstmid_iready: got %0b expected 1", bus.iready); end
      n_checks++; if (bus.a !== 8'h00 || bus.aluop !== 1'b0) begin n_fail++; $display("FAIL rstmid_ops: got a=%0h aluop=%0b expected 0/0", bus.a, bus.aluop); end
      repeat (4) begin
         if (bus.done) seen_done = 1'b1;
         @(negedge clk);
      end
      n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got 1 expected 0"); end
      for (int r = 0; r < 4; r++) begin
         bus.raddr = 2'(r);
         #1;
         n_checks++; if (bus.rdata !== mdl[r]) begin n_fail++; $display("FAIL rstmid_rdata r%0d: got %0h expected %0h", r, bus.rdata, mdl[r]); end
      end
      $display("reset mid-op: iready=%0b r3=%02h", bus.iready, mdl[3]);
   endtask

   initial begin
      rst = 1'b1;
      bus.ivalid = 1'b0;
      bus.instr  = 8'h00;
      bus.raddr  = 2'd0;
      test_reset();
      test_ldi_add();
      test_overflow();
      test_back_to_back();
      test_clr_nop();
      test_reset_mid();
      n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #(20000 * P);
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
